// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register map, class
// FSM state encoding and the fixed-priority winner selection.
package intc_pkg;

    localparam logic [2:0] INTC_ENABLE  = 3'd0;
    localparam logic [2:0] INTC_FIQSEL  = 3'd1;
    localparam logic [2:0] INTC_EDGE    = 3'd2;
    localparam logic [2:0] INTC_PENDING = 3'd3;
    localparam logic [2:0] INTC_IRQID   = 3'd4;
    localparam logic [2:0] INTC_FIQID   = 3'd5;
    localparam logic [2:0] INTC_EOI     = 3'd6;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_PEND    = 2'd1,
        IC_SERVICE = 2'd2
    } intc_state_t;

    // Index of the lowest set bit; lowest index has the highest priority.
    // Returns 0 for an all-zero vector, so callers must qualify with |v.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/intc_if.sv
// Register bus and exception_handler handshake of the interrupt controller.
// The master side is the CPU / exception handler, the slave side is the
// controller itself.
interface intc_if;
    logic        IRQAssert;
    logic        FIQAssert;
    logic        RegWE;
    logic [2:0]  RegAddr;
    logic [31:0] RegWD;
    logic [31:0] RegRD;
    logic        IRQ;
    logic        FIQ;

    modport master (
        output IRQAssert, FIQAssert, RegWE, RegAddr, RegWD,
        input  RegRD, IRQ, FIQ
    );

    modport slave (
        input  IRQAssert, FIQAssert, RegWE, RegAddr, RegWD,
        output RegRD, IRQ, FIQ
    );
endinterface

// File: rtl/intc_class_fsm.sv
// One interrupt class (IRQ or FIQ): IDLE/PEND/SERVICE sequencing, the
// request line and the latched ID of the source being serviced.
module intc_class_fsm
    import intc_pkg::*;
#(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] cand_i,
    input  logic            ack_i,
    input  logic            eoi_i,
    output logic            line_o,
    output logic            id_valid_o,
    output logic [4:0]      id_o,
    output logic            take_o,
    output logic [4:0]      win_o
);

    intc_state_t state_q, state_d;
    logic        vld_q, vld_d;
    logic [4:0]  id_q, id_d;
    logic [31:0] cand32;

    // Next-state logic: cancel wins over a simultaneous ack, and the winner
    // ID is captured only when the ack actually moves us into SERVICE.
    always_comb begin
        cand32             = '0;
        cand32[NSRC-1:0]   = cand_i;
        win_o              = lowest_set(cand32);
        state_d            = state_q;
        vld_d              = vld_q;
        id_d               = id_q;
        take_o             = 1'b0;
        case (state_q)
            IC_IDLE: begin
                if (|cand_i) state_d = IC_PEND;
            end
            IC_PEND: begin
                if (!(|cand_i)) begin
                    state_d = IC_IDLE;
                end else if (ack_i) begin
                    state_d = IC_SERVICE;
                    id_d    = win_o;
                    vld_d   = 1'b1;
                    take_o  = 1'b1;
                end
            end
            IC_SERVICE: begin
                if (eoi_i) begin
                    state_d = IC_IDLE;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = IC_IDLE;
        endcase
    end

    // State and ID registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IC_IDLE;
            vld_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
        end
    end

    assign line_o     = (state_q == IC_PEND);
    assign id_valid_o = vld_q;
    assign id_o       = id_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller top: source synchronisers, pending/config
// registers, register read mux and the two class FSMs (IRQ and FIQ).
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int NSRC        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] IntSrc,
    intc_if.slave           bus
);

    logic [NSRC-1:0] sync_q [SYNC_STAGES];
    logic [NSRC-1:0] s_prev_q;
    logic [NSRC-1:0] enable_q, fiqsel_q, edge_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] s, rise, w1c, ack_clr, en, irqc, fiqc;
    logic            irq_take, fiq_take, irq_vld, fiq_vld;
    logic [4:0]      irq_win, fiq_win, irq_id, fiq_id;
    logic            eoi_irq, eoi_fiq;
    logic [31:0]     rd_data;
    logic            unused_wd;

    assign s         = sync_q[SYNC_STAGES-1];
    assign en        = pending_q & enable_q;
    assign fiqc      = en & fiqsel_q;
    assign irqc      = en & ~fiqsel_q;
    assign eoi_irq   = bus.RegWE && (bus.RegAddr == INTC_EOI) && bus.RegWD[0];
    assign eoi_fiq   = bus.RegWE && (bus.RegAddr == INTC_EOI) && bus.RegWD[1];
    assign unused_wd = &{1'b0, bus.RegWD};

    // Synchroniser chain per source plus the previous synchronised value for
    // rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            s_prev_q <= '0;
        end else begin
            sync_q[0] <= IntSrc;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            s_prev_q <= s;
        end
    end

    // Pending next state: edge bits latch rises and clear on W1C or on being
    // taken by a class (a new rise in the same cycle wins); level bits follow s.
    always_comb begin
        rise    = s & ~s_prev_q;
        w1c     = '0;
        ack_clr = '0;
        if (bus.RegWE && (bus.RegAddr == INTC_PENDING)) w1c = bus.RegWD[NSRC-1:0];
        for (int i = 0; i < NSRC; i++) begin
            if ((irq_take && (irq_win == 5'(i))) || (fiq_take && (fiq_win == 5'(i))))
                ack_clr[i] = 1'b1;
        end
        pending_d = (edge_q & ((pending_q & ~w1c & ~ack_clr) | rise)) | (~edge_q & s);
    end

    // Configuration and pending registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q  <= '0;
            fiqsel_q  <= '0;
            edge_q    <= '0;
            pending_q <= '0;
        end else begin
            if (bus.RegWE && (bus.RegAddr == INTC_ENABLE)) enable_q <= bus.RegWD[NSRC-1:0];
            if (bus.RegWE && (bus.RegAddr == INTC_FIQSEL)) fiqsel_q <= bus.RegWD[NSRC-1:0];
            if (bus.RegWE && (bus.RegAddr == INTC_EDGE))   edge_q   <= bus.RegWD[NSRC-1:0];
            pending_q <= pending_d;
        end
    end

    intc_class_fsm #(.NSRC(NSRC)) u_irq (
        .clk       (clk),
        .reset     (reset),
        .cand_i    (irqc),
        .ack_i     (bus.IRQAssert),
        .eoi_i     (eoi_irq),
        .line_o    (bus.IRQ),
        .id_valid_o(irq_vld),
        .id_o      (irq_id),
        .take_o    (irq_take),
        .win_o     (irq_win)
    );

    intc_class_fsm #(.NSRC(NSRC)) u_fiq (
        .clk       (clk),
        .reset     (reset),
        .cand_i    (fiqc),
        .ack_i     (bus.FIQAssert),
        .eoi_i     (eoi_fiq),
        .line_o    (bus.FIQ),
        .id_valid_o(fiq_vld),
        .id_o      (fiq_id),
        .take_o    (fiq_take),
        .win_o     (fiq_win)
    );

    // Combinational register read; unused bits read as zero.
    always_comb begin
        rd_data = '0;
        case (bus.RegAddr)
            INTC_ENABLE:  rd_data[NSRC-1:0] = enable_q;
            INTC_FIQSEL:  rd_data[NSRC-1:0] = fiqsel_q;
            INTC_EDGE:    rd_data[NSRC-1:0] = edge_q;
            INTC_PENDING: rd_data[NSRC-1:0] = pending_q;
            INTC_IRQID: begin
                rd_data[31]  = irq_vld;
                rd_data[4:0] = irq_id;
            end
            INTC_FIQID: begin
                rd_data[31]  = fiq_vld;
                rd_data[4:0] = fiq_id;
            end
            default: rd_data = '0;
        endcase
    end

    assign bus.RegRD = rd_data;

endmodule
